// File: rtl/seg_p2s_shifter.sv
// Serialises a 64-bit active-low segment image LSB-first into a 74x164 chain.
// Each bit is DIV cycles with s_clk low for setup, then DIV cycles with s_clk high.
module seg_p2s_shifter #(
  parameter int DIV  = 2,
  parameter bit AUTO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] seg_txt_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        s_clk_o,
  output logic        s_dat_o,
  output logic        s_pen_o,
  output logic        s_clrn_o
);

  localparam int             DW       = $clog2(DIV) + 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q;
  logic [63:0]   shreg_q;
  logic [5:0]    bitcnt_q;
  logic [DW-1:0] divcnt_q, divcnt_d;
  logic          busy_q, done_q, s_clk_q, s_pen_q, s_clrn_q;
  logic          phase_end, last_bit;

  assign phase_end = (divcnt_q == DIV_LAST);
  assign last_bit  = (bitcnt_q == 6'd63);
  assign divcnt_d  = phase_end ? '0 : divcnt_q + DW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_clk_q  <= 1'b0;
      s_pen_q  <= 1'b1;
      s_clrn_q <= 1'b0;
    end else begin
      s_clrn_q <= 1'b1;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i || AUTO) begin
            state_q  <= SHIFT;
            shreg_q  <= seg_txt_i;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            busy_q   <= 1'b1;
            s_pen_q  <= 1'b0;
            s_clk_q  <= 1'b0;
          end
        end
        SHIFT: begin
          divcnt_q <= divcnt_d;
          if (phase_end) begin
            if (!s_clk_q) begin
              s_clk_q <= 1'b1;
            end else if (last_bit) begin
              // shreg_q[0] keeps bit 63, so serial data holds the last bit
              state_q <= IDLE;
              busy_q  <= 1'b0;
              s_clk_q <= 1'b0;
              s_pen_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              // next bit appears together with the falling serial clock
              s_clk_q  <= 1'b0;
              shreg_q  <= {1'b0, shreg_q[63:1]};
              bitcnt_q <= bitcnt_q + 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign s_clk_o  = s_clk_q;
  assign s_dat_o  = shreg_q[0];
  assign s_pen_o  = s_pen_q;
  assign s_clrn_o = s_clrn_q;

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Directed bench: inst 0 DIV=2 manual start, inst 1 DIV=1 AUTO, inst 2 DIV=1 start held high.
module tb_seg_p2s_shifter;

  logic        clk = 1'b0;
  logic        rst_w   [3];
  logic        start_w [3];
  logic [63:0] seg_w   [3];
  logic        busy_w[3], done_w[3], s_clk_w[3], s_dat_w[3], s_pen_w[3], s_clrn_w[3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // serial-side monitor state, written only by the monitor process
  logic [511:0] capb     [3];
  int           ncap     [3] = '{0, 0, 0};
  int           busycnt  [3] = '{0, 0, 0};
  int           donecnt  [3] = '{0, 0, 0};
  int           gapbad   [3] = '{0, 0, 0};
  int           unstable [3] = '{0, 0, 0};
  int           lastdone [3] = '{-1, -1, -1};
  logic         pclk     [3] = '{1'b0, 1'b0, 1'b0};
  logic         rise_dat [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seg_p2s_shifter #(.DIV(2), .AUTO(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst_w[0]), .seg_txt_i(seg_w[0]), .start_i(start_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .s_clk_o(s_clk_w[0]), .s_dat_o(s_dat_w[0]),
    .s_pen_o(s_pen_w[0]), .s_clrn_o(s_clrn_w[0]));

  seg_p2s_shifter #(.DIV(1), .AUTO(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst_w[1]), .seg_txt_i(seg_w[1]), .start_i(start_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .s_clk_o(s_clk_w[1]), .s_dat_o(s_dat_w[1]),
    .s_pen_o(s_pen_w[1]), .s_clrn_o(s_clrn_w[1]));

  seg_p2s_shifter #(.DIV(1), .AUTO(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst_w[2]), .seg_txt_i(seg_w[2]), .start_i(start_w[2]),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .s_clk_o(s_clk_w[2]), .s_dat_o(s_dat_w[2]),
    .s_pen_o(s_pen_w[2]), .s_clrn_o(s_clrn_w[2]));

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (s_clk_w[k] && !pclk[k]) begin
        capb[k][ncap[k] % 512] = s_dat_w[k];
        ncap[k]++;
        rise_dat[k] = s_dat_w[k];
      end else if (s_clk_w[k] && pclk[k] && s_dat_w[k] !== rise_dat[k]) begin
        unstable[k]++;
      end
      if (busy_w[k]) busycnt[k]++;
      if (done_w[k]) begin
        donecnt[k]++;
        if (lastdone[k] >= 0 && cyc - lastdone[k] != 129) gapbad[k]++;
        lastdone[k] = cyc;
      end
      pclk[k] = s_clk_w[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] frame(input int k, input int base);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) f[i] = capb[k][(base + i) % 512];
    return f;
  endfunction

  task automatic start_frame(input int k, input logic [63:0] seg);
    seg_w[k]   = seg;
    start_w[k] = 1'b1;
    tick();
    start_w[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int bound, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_w[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  int          b_cap, b_busy, b_done;
  logic [63:0] sv;
  logic        ok;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_w[k] = 1'b1; start_w[k] = 1'b0; seg_w[k] = '0;
    end
    repeat (3) tick();

    // reset values
    chk("rst_busy",  64'(busy_w[0]),   64'd0);
    chk("rst_done",  64'(done_w[0]),   64'd0);
    chk("rst_sclk",  64'(s_clk_w[0]),  64'd0);
    chk("rst_sdat",  64'(s_dat_w[0]),  64'd0);
    chk("rst_spen",  64'(s_pen_w[0]),  64'd1);
    chk("rst_sclrn", 64'(s_clrn_w[0]), 64'd0);
    rst_w[0] = 1'b0;
    tick();
    chk("clrn_release", 64'(s_clrn_w[0]), 64'd1);
    chk("idle_busy",    64'(busy_w[0]),   64'd0);

    // 1: basic frame, DIV=2
    b_cap = ncap[0]; b_busy = busycnt[0]; b_done = donecnt[0];
    start_frame(0, 64'h0123456789ABCDEF);
    chk("t1_busy_load", 64'(busy_w[0]),  64'd1);
    chk("t1_spen_load", 64'(s_pen_w[0]), 64'd0);
    chk("t1_sdat_bit0", 64'(s_dat_w[0]), 64'd1);
    tick();
    chk("t1_sclk_low",  64'(s_clk_w[0]), 64'd0);
    tick();
    chk("t1_sclk_high", 64'(s_clk_w[0]), 64'd1);
    wait_done(0, 400, "t1");
    chk("t1_busy_end",  64'(busy_w[0]),  64'd0);
    chk("t1_spen_end",  64'(s_pen_w[0]), 64'd1);
    chk("t1_sclk_end",  64'(s_clk_w[0]), 64'd0);
    chk("t1_sdat_last", 64'(s_dat_w[0]), 64'd0);
    chk("t1_nbits",     64'(ncap[0] - b_cap),      64'd64);
    chk("t1_frame",     frame(0, b_cap),           64'h0123456789ABCDEF);
    chk("t1_busy_cyc",  64'(busycnt[0] - b_busy),  64'd256);
    chk("t1_ndone",     64'(donecnt[0] - b_done),  64'd1);
    tick();
    chk("t1_done_pulse", 64'(done_w[0]), 64'd0);

    // 2: start pulses mid-frame are ignored
    b_cap = ncap[0]; b_busy = busycnt[0]; b_done = donecnt[0];
    start_frame(0, 64'hFEDCBA9876543210);
    repeat (8) tick();
    start_w[0] = 1'b1; tick(); start_w[0] = 1'b0;
    repeat (88) tick();
    start_w[0] = 1'b1; tick(); start_w[0] = 1'b0;
    wait_done(0, 300, "t2");
    chk("t2_frame",    frame(0, b_cap),          64'hFEDCBA9876543210);
    chk("t2_busy_cyc", 64'(busycnt[0] - b_busy), 64'd256);
    chk("t2_ndone",    64'(donecnt[0] - b_done), 64'd1);
    chk("t2_sdat_last", 64'(s_dat_w[0]), 64'd1);

    // 3: start in the done cycle is accepted; later seg_txt changes are not shifted
    b_cap = ncap[0]; b_done = donecnt[0];
    start_frame(0, 64'hA5A50F0F3C3C9669);
    chk("t3_gap1_busy", 64'(busy_w[0]), 64'd1);
    repeat (4) tick();
    seg_w[0] = '1;
    wait_done(0, 300, "t3");
    chk("t3_frame", frame(0, b_cap),          64'hA5A50F0F3C3C9669);
    chk("t3_ndone", 64'(donecnt[0] - b_done), 64'd1);
    repeat (10) tick();
    chk("t3_no_requeue_busy", 64'(busy_w[0]),             64'd0);
    chk("t3_no_requeue_done", 64'(donecnt[0] - b_done),   64'd1);

    // 4: reset at bit 30 drops the frame
    b_cap = ncap[0]; b_done = donecnt[0];
    start_frame(0, 64'h1122334455667788);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ncap[0] - b_cap == 31) begin ok = 1'b1; break; end
      tick();
    end
    chk("t4_reach_bit30", 64'(ok), 64'd1);
    rst_w[0] = 1'b1;
    tick();
    chk("t4_busy",  64'(busy_w[0]),   64'd0);
    chk("t4_spen",  64'(s_pen_w[0]),  64'd1);
    chk("t4_sclk",  64'(s_clk_w[0]),  64'd0);
    chk("t4_sclrn", 64'(s_clrn_w[0]), 64'd0);
    chk("t4_done",  64'(done_w[0]),   64'd0);
    rst_w[0] = 1'b0;
    repeat (140) tick();
    chk("t4_no_done", 64'(donecnt[0] - b_done), 64'd0);
    b_cap = ncap[0];
    start_frame(0, 64'hDEADBEEFCAFEF00D);
    wait_done(0, 300, "t4b");
    chk("t4_frame_after", frame(0, b_cap),          64'hDEADBEEFCAFEF00D);
    chk("t4_ndone_after", 64'(donecnt[0] - b_done), 64'd1);
    chk("t0_sdat_stable", 64'(unstable[0]),         64'd0);

    // 5: AUTO=1 DIV=1 ; 6: DIV=1 with start held high
    start_w[2] = 1'b1;
    for (int k = 1; k < 3; k++) begin
      sv = (k == 1) ? 64'hC3C35A5A0000FFFF : 64'h0F1E2D3C4B5A6978;
      seg_w[k] = sv;
      b_cap = ncap[k]; b_busy = busycnt[k]; b_done = donecnt[k];
      rst_w[k] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        tick();
        if (donecnt[k] - b_done == 3) begin ok = 1'b1; break; end
      end
      rst_w[k] = 1'b1;
      chk($sformatf("t%0d_three_frames", k + 4), 64'(ok), 64'd1);
      chk($sformatf("t%0d_busy_cyc", k + 4),   64'(busycnt[k] - b_busy), 64'd384);
      chk($sformatf("t%0d_done_gap", k + 4),   64'(gapbad[k]),           64'd0);
      chk($sformatf("t%0d_nbits", k + 4),      64'(ncap[k] - b_cap),     64'd192);
      chk($sformatf("t%0d_frame", k + 4),      frame(k, ncap[k] - 64),   sv);
      chk($sformatf("t%0d_sdat_stable", k + 4), 64'(unstable[k]),        64'd0);
      tick();
    end
    start_w[2] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
